// File: rtl/hilo_div_ctrl_if.sv
// Issue/result bus between the HI/LO divide controller (master) and the iterative divider (slave).
interface hilo_div_ctrl_if;
  localparam int unsigned DW = 32;

  logic [1:0]      div_op;
  logic [DW-1:0]   divisor;
  logic [DW-1:0]   dividend;
  logic [2*DW-1:0] div_result;
  logic            div_done;

  modport master (output div_op, divisor, dividend, input div_result, div_done);
  modport slave  (input div_op, divisor, dividend, output div_result, div_done);
endinterface

// File: rtl/hilo_div_ctrl.sv
// EX-stage divide issue/stall controller that also owns the architectural HI/LO registers.
// Optional macro DIV_ZERO_SKIP_EN: a divide with a zero divisor is dropped in IDLE instead of issued.
module hilo_div_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 48
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      ex_div_op,
  input  logic [31:0]     ex_rs,
  input  logic [31:0]     ex_rt,
  input  logic            ex_mthi,
  input  logic            ex_mtlo,
  input  logic [31:0]     ex_wdata,
  input  logic            flush,
  output logic            stall_o,
  output logic [31:0]     hi,
  output logic [31:0]     lo,
  output logic            div_err,
  hilo_div_ctrl_if.master dbus
);
  localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0]  OP_DIVU = 2'b01;
  localparam logic [1:0]  OP_DIV  = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DRAIN = 2'd2} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             req;
  logic             skip;
  logic             timeout;
  logic             issue;
  logic             capture;
  logic             mt_en;

  assign req = (ex_div_op == OP_DIVU || ex_div_op == OP_DIV) && !flush;

`ifdef DIV_ZERO_SKIP_EN
  assign skip = (ex_rt == 32'd0);
`else
  assign skip = 1'b0;
`endif

  // Divider never answered within the budget: abandon the wait.
  assign timeout = (state != IDLE) && !dbus.div_done &&
                   (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign dbus.div_op   = issue ? ex_div_op : 2'b00;
  assign dbus.divisor  = ex_rt;
  assign dbus.dividend = ex_rs;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req && !skip && dbus.div_done) state_next = BUSY;
      end
      BUSY: begin
        if (timeout || dbus.div_done) state_next = IDLE;
        else if (flush)               state_next = DRAIN;
      end
      DRAIN: begin
        if (timeout)            state_next = IDLE;
        else if (dbus.div_done) state_next = req ? BUSY : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A pending divide always blocks MTHI/MTLO in the same cycle.
  always_comb begin
    stall_o = 1'b0;
    issue   = 1'b0;
    capture = 1'b0;
    mt_en   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (!skip) begin
            stall_o = 1'b1;
            issue   = dbus.div_done;
          end
        end else begin
          mt_en = 1'b1;
        end
      end
      BUSY: begin
        stall_o = !dbus.div_done && !flush && !timeout;
        capture = dbus.div_done && !flush;
      end
      DRAIN: begin
        if (req) begin
          stall_o = 1'b1;
          issue   = dbus.div_done;
        end else begin
          mt_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      div_err <= 1'b0;
      cnt     <= '0;
    end else begin
      if (timeout) div_err <= 1'b1;

      if (state_next != state)  cnt <= '0;
      else if (state != IDLE)   cnt <= cnt + CNT_W'(1);

      if (capture) begin
        hi <= dbus.div_result[63:32];
        lo <= dbus.div_result[31:0];
      end else if (mt_en && !flush) begin
        if (ex_mthi) hi <= ex_wdata;
        if (ex_mtlo) lo <= ex_wdata;
      end
    end
  end
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl with a behavioural 34-cycle divider stand-in.
module tb_hilo_div_ctrl;
  localparam int unsigned TO = 48;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ex_div_op;
  logic [31:0] ex_rs, ex_rt, ex_wdata;
  logic        ex_mthi, ex_mtlo, flush;
  logic        stall_o, div_err;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  hilo_div_ctrl_if dif();

  hilo_div_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ex_div_op(ex_div_op), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_mthi(ex_mthi), .ex_mtlo(ex_mtlo), .ex_wdata(ex_wdata), .flush(flush),
    .stall_o(stall_o), .hi(hi), .lo(lo), .div_err(div_err), .dbus(dif.master)
  );

  // Arithmetic reference: {remainder, quotient}; zero divisor returns {dividend, all ones}.
  function automatic logic [63:0] div_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (op == 2'b10) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Divider stand-in: busy 34 cycles (+stretch) after an accepted issue.
  int unsigned dcnt;
  int unsigned stretch;
  logic [63:0] dres;
  always @(posedge clk) begin
    if (rst) begin
      dcnt <= 0;
      dres <= '0;
    end else if (dcnt == 0 && dif.div_op != 2'b00) begin
      dcnt <= 34 + stretch;
      dres <= div_ref(dif.div_op, dif.dividend, dif.divisor);
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
    end
  end
  assign dif.div_done   = (dcnt == 0);
  assign dif.div_result = dres;

  int passed = 0;
  int total  = 0;
  logic [31:0] mhi, mlo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Watches one EX instruction until stall_o drops; assumes inputs were just set at a negedge.
  task automatic wait_div(output int stalls, output int pre, output int issues,
                          output logic [1:0] op_seen, output logic [63:0] hl_post);
    logic ok;
    int   issue_at;
    ok = 1'b0; issue_at = -1;
    stalls = 0; pre = 0; issues = 0; op_seen = 2'b00; hl_post = '0;
    for (int i = 0; i < 300; i++) begin
      logic st;
      #1;
      st = stall_o;
      if (issue_at >= 0 && i == issue_at + 1) hl_post = {hi, lo};
      if (dif.div_op != 2'b00) begin
        issues++;
        op_seen = dif.div_op;
        if (issue_at < 0) issue_at = i;
      end
      if (st) begin
        stalls++;
        if (issue_at < 0) pre++;
      end
      @(negedge clk);
      if (!st) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_bound", 64'(ok), 64'd1);
  endtask

  task automatic run_div(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic mthi_too, output int stalls, output int issues,
                         output logic [1:0] op_seen, output logic [63:0] hl_post);
    int pre;
    @(negedge clk);
    ex_div_op = op; ex_rs = rs; ex_rt = rt; ex_mthi = mthi_too; ex_wdata = 32'hDEAD_BEEF;
    wait_div(stalls, pre, issues, op_seen, hl_post);
    ex_div_op = 2'b00; ex_mthi = 1'b0;
  endtask

  task automatic do_mt(input logic h, input logic l, input logic fl, input logic [31:0] d, input string nm);
    @(negedge clk);
    ex_mthi = h; ex_mtlo = l; flush = fl; ex_wdata = d;
    #1 check({nm, "_stall"}, 64'(stall_o), 64'd0);
    @(negedge clk);
    ex_mthi = 1'b0; ex_mtlo = 1'b0; flush = 1'b0;
    if (!fl) begin
      if (h) mhi = d;
      if (l) mlo = d;
    end
    check({nm, "_hi"}, 64'(hi), 64'(mhi));
    check({nm, "_lo"}, 64'(lo), 64'(mlo));
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1; ex_div_op = 2'b00; ex_mthi = 1'b0; ex_mtlo = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mhi = 32'd0; mlo = 32'd0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        mt;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vt[6];

  initial begin
    int st, pre, iss;
    logic [1:0]  ops;
    logic [63:0] hl, exp;

    vt[0] = '{2'b01, 32'd100,        32'd7,          1'b0, 32'd2,          32'd14};
    vt[1] = '{2'b10, 32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFD};
    vt[2] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          32'hFFFF_FFFF};
    vt[3] = '{2'b10, 32'd100,        32'hFFFF_FFF9,  1'b1, 32'd2,          32'hFFFF_FFF2};
    vt[4] = '{2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b0, 32'hFFFF_FFFE,  32'd14};
    vt[5] = '{2'b01, 32'd5,          32'd9,          1'b1, 32'd5,          32'd0};

    stretch = 0;
    rst = 1'b1; ex_div_op = 2'b00; ex_rs = '0; ex_rt = '0; ex_wdata = '0;
    ex_mthi = 1'b0; ex_mtlo = 1'b0; flush = 1'b0;
    mhi = 32'd0; mlo = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_err", 64'(div_err), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    check("rst_div_op", 64'(dif.div_op), 64'd0);

    // Directed divides; mt flag also drives MTHI, which must be ignored.
    foreach (vt[k]) begin
      run_div(vt[k].op, vt[k].rs, vt[k].rt, vt[k].mt, st, iss, ops, hl);
      check($sformatf("vec%0d_stalls", k), 64'(st), 64'd35);
      check($sformatf("vec%0d_issues", k), 64'(iss), 64'd1);
      check($sformatf("vec%0d_op", k), 64'(ops), 64'(vt[k].op));
      check($sformatf("vec%0d_hold", k), hl, {mhi, mlo});
      check($sformatf("vec%0d_hi", k), 64'(hi), 64'(vt[k].ehi));
      check($sformatf("vec%0d_lo", k), 64'(lo), 64'(vt[k].elo));
      mhi = vt[k].ehi; mlo = vt[k].elo;
    end

    do_mt(1'b1, 1'b1, 1'b0, 32'hA5A5_A5A5, "mt_both");
    do_mt(1'b0, 1'b1, 1'b0, 32'h5A5A_5A5A, "mt_lo");
    do_mt(1'b1, 1'b0, 1'b1, 32'h1111_2222, "mt_flushed");

    // Flush in BUSY at T+5, new DIVU from T+6 waits for the divider, then issues.
    @(negedge clk);
    ex_div_op = 2'b01; ex_rs = 32'd1000; ex_rt = 32'd10;
    #1 check("flush_issue_op", 64'(dif.div_op), 64'd1);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    #1 check("flush_stall_drop", 64'(stall_o), 64'd0);
    @(negedge clk);
    flush = 1'b0; ex_rs = 32'd77; ex_rt = 32'd5;
    wait_div(st, pre, iss, ops, hl);
    ex_div_op = 2'b00;
    check("drain_pre_stalls", 64'(pre), 64'd29);
    check("drain_total_stalls", 64'(st), 64'd64);
    check("drain_issues", 64'(iss), 64'd1);
    check("drain_discard", hl, {mhi, mlo});
    check("drain_new_hi", 64'(hi), 64'd2);
    check("drain_new_lo", 64'(lo), 64'd15);
    mhi = 32'd2; mlo = 32'd15;

    // Flush landing on the same cycle the result returns.
    @(negedge clk);
    ex_div_op = 2'b01; ex_rs = 32'd50; ex_rt = 32'd7;
    repeat (35) @(negedge clk);
    flush = 1'b1;
    #1 check("flush_done_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    flush = 1'b0; ex_div_op = 2'b00;
    check("flush_done_hi", 64'(hi), 64'(mhi));
    check("flush_done_lo", 64'(lo), 64'(mlo));

    // Divide by zero.
    run_div(2'b01, 32'd123, 32'd0, 1'b0, st, iss, ops, hl);
`ifdef DIV_ZERO_SKIP_EN
    check("dz_stalls", 64'(st), 64'd0);
    check("dz_issues", 64'(iss), 64'd0);
`else
    check("dz_stalls", 64'(st), 64'd35);
    check("dz_issues", 64'(iss), 64'd1);
    mhi = 32'd123; mlo = 32'hFFFF_FFFF;
`endif
    check("dz_hi", 64'(hi), 64'(mhi));
    check("dz_lo", 64'(lo), 64'(mlo));

    // Randomized traffic against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      int unsigned kind;
      logic [1:0]  op;
      logic [31:0] rs, rt;
      kind = $urandom_range(0, 3);
      if (kind <= 1) begin
        op = (kind == 0) ? 2'b01 : 2'b10;
        rs = $urandom;
        rt = $urandom_range(0, 1) ? 32'($urandom_range(1, 20)) : $urandom;
        if (op == 2'b10 && $urandom_range(0, 1)) rt = -rt;
        if (rt == 32'd0) rt = 32'd1;
        if (op == 2'b10 && rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) rt = 32'd1;
        run_div(op, rs, rt, 1'b0, st, iss, ops, hl);
        exp = div_ref(op, rs, rt);
        mhi = exp[63:32]; mlo = exp[31:0];
        check($sformatf("rnd%0d_stalls", n), 64'(st), 64'd35);
        check($sformatf("rnd%0d_hi", n), 64'(hi), 64'(mhi));
        check($sformatf("rnd%0d_lo", n), 64'(lo), 64'(mlo));
      end else if (kind == 2) begin
        do_mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
              $urandom, $sformatf("rnd%0d_mt", n));
      end else begin
        @(negedge clk);
        check($sformatf("rnd%0d_idle", n), {hi, lo}, {mhi, mlo});
      end
    end

    // Divider never answers: timeout releases the stall and sets the sticky error.
    stretch = 60;
    run_div(2'b01, 32'd9, 32'd3, 1'b0, st, iss, ops, hl);
    check("to_stall_window", 64'(st >= TO - 1 && st <= TO + 1), 64'd1);
    check("to_err", 64'(div_err), 64'd1);
    check("to_hi", 64'(hi), 64'(mhi));
    check("to_lo", 64'(lo), 64'(mlo));
    stretch = 0;
    pulse_rst();
    #1;
    check("to_rst_err", 64'(div_err), 64'd0);

    // Reset in the middle of a divide.
    do_mt(1'b1, 1'b1, 1'b0, 32'h1234_5678, "pre_rst_mt");
    @(negedge clk);
    ex_div_op = 2'b01; ex_rs = 32'd10; ex_rt = 32'd3;
    repeat (10) @(negedge clk);
    pulse_rst();
    #1;
    check("mid_rst_stall", 64'(stall_o), 64'd0);
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    check("mid_rst_err", 64'(div_err), 64'd0);
    run_div(vt[0].op, vt[0].rs, vt[0].rt, 1'b0, st, iss, ops, hl);
    check("post_rst_stalls", 64'(st), 64'd35);
    check("post_rst_hi", 64'(hi), 64'(vt[0].ehi));
    check("post_rst_lo", 64'(lo), 64'(vt[0].elo));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
